// File: rtl/bin_to_bcd_serial.sv
// Serial 32-bit binary to nine-digit packed BCD converter (double dabble, one bit per clock).
// Valid/ready handshake on both sides; out_ovf flags operands of ten decimal digits.
module bin_to_bcd_serial (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_bin,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [35:0] out_bcd,
    output logic        out_ovf,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_bin;
    logic [39:0] r_scratch;
    logic [5:0]  r_cnt;
    logic        r_in_ready;
    logic        r_out_valid;
    logic [35:0] r_out_bcd;
    logic        r_out_ovf;

    logic [39:0] w_adj;
    logic [39:0] w_next_scratch;

    // Add-3 correction on every digit >= 5, then shift in the next binary MSB.
    always_comb begin
        w_adj = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
            else
                w_adj[4*i +: 4] = r_scratch[4*i +: 4];
        end
        w_next_scratch = {w_adj[38:0], r_bin[31]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_bin       <= '0;
            r_scratch   <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_bcd   <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_bin      <= in_bin;
                        r_scratch  <= '0;
                        r_cnt      <= 6'd32;
                        r_in_ready <= 1'b0;
                        r_state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_scratch <= w_next_scratch;
                    r_bin     <= {r_bin[30:0], 1'b0};
                    r_cnt     <= r_cnt - 6'd1;
                    // Result outputs are captured with the final step so they are
                    // already valid in the first DONE cycle and held through IDLE.
                    if (r_cnt == 6'd1) begin
                        r_out_bcd   <= w_next_scratch[35:0];
                        r_out_ovf   <= (w_next_scratch[39:36] != 4'd0);
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_bcd   = r_out_bcd;
    assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// Directed self-checking bench for bin_to_bcd_serial: values, latency, backpressure,
// mid-conversion reset and input changes during conversion.
module tb_bin_to_bcd_serial;

    logic        clk;
    logic        rst;
    logic [31:0] in_bin;
    logic        in_valid;
    logic        in_ready;
    logic [35:0] out_bcd;
    logic        out_ovf;
    logic        out_valid;
    logic        out_ready;

    int n_cmp;
    int n_bad;

    bin_to_bcd_serial dut (
        .clk       (clk),
        .rst       (rst),
        .in_bin    (in_bin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_bcd   (out_bcd),
        .out_ovf   (out_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one accept edge; returns just after it.
    task automatic start_op(input logic [31:0] v);
        in_bin   = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid, bounded at 40.
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        n_cmp++;
        if (out_bcd !== 36'h0 || out_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_data: out_bcd=%h out_ovf=%b required 000000000/0", out_bcd, out_ovf);
        end
    endtask

    task automatic test_zero();
        int n;
        start_op(32'd0);
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_busy: in_ready=%b required 0", in_ready);
        end
        wait_valid(n);
        n_cmp++;
        if (n !== 32) begin
            n_bad++;
            $display("FAIL zero_latency: edges after accept=%0d required 32", n);
        end
        n_cmp++;
        if (out_bcd !== 36'h000000000 || out_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_value: out_bcd=%h out_ovf=%b required 000000000/0", out_bcd, out_ovf);
        end
        release_result();
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_values();
        logic [31:0] vin  [4];
        logic [35:0] vbcd [4];
        logic        vovf [4];
        int n;
        vin[0] = 32'd12345678;   vbcd[0] = 36'h012345678; vovf[0] = 1'b0;
        vin[1] = 32'd999999999;  vbcd[1] = 36'h999999999; vovf[1] = 1'b0;
        vin[2] = 32'd1000000000; vbcd[2] = 36'h000000000; vovf[2] = 1'b1;
        vin[3] = 32'hFFFFFFFF;   vbcd[3] = 36'h294967295; vovf[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start_op(vin[i]);
            wait_valid(n);
            n_cmp++;
            if (n !== 32 || out_bcd !== vbcd[i] || out_ovf !== vovf[i]) begin
                n_bad++;
                $display("FAIL value_%0d: in=%0d edges=%0d out_bcd=%h out_ovf=%b required 32 %h %b",
                         i, vin[i], n, out_bcd, out_ovf, vbcd[i], vovf[i]);
            end
            release_result();
            n_cmp++;
            if (out_bcd !== vbcd[i] || out_ovf !== vovf[i] || in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL idle_hold_%0d: out_bcd=%h out_ovf=%b in_ready=%b required %h %b 1",
                         i, out_bcd, out_ovf, in_ready, vbcd[i], vovf[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        int bad;
        start_op(32'd987654321);
        wait_valid(n);
        bad = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_bin   = 32'd5 + i;
            tick();
            if (out_bcd !== 36'h987654321 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL backpressure_hold: %0d unstable cycles, last out_bcd=%h in_ready=%b out_valid=%b required 987654321 0 1",
                     bad, out_bcd, in_ready, out_valid);
        end
        // in_valid still high on the release edge: must not be accepted there.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_bcd !== 36'h987654321) begin
            n_bad++;
            $display("FAIL backpressure_release: in_ready=%b out_valid=%b out_bcd=%h required 1 0 987654321",
                     in_ready, out_valid, out_bcd);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        start_op(32'd123456789);
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_bcd !== 36'h0 || out_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid: in_ready=%b out_valid=%b out_bcd=%h out_ovf=%b required 1 0 000000000 0",
                     in_ready, out_valid, out_bcd, out_ovf);
        end
        start_op(32'd42);
        wait_valid(n);
        n_cmp++;
        if (n !== 32 || out_bcd !== 36'h000000042 || out_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL after_reset: edges=%0d out_bcd=%h out_ovf=%b required 32 000000042 0", n, out_bcd, out_ovf);
        end
        release_result();
    endtask

    task automatic test_reset_done();
        int n;
        start_op(32'd77);
        wait_valid(n);
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_bcd !== 36'h0) begin
            n_bad++;
            $display("FAIL reset_done: out_valid=%b in_ready=%b out_bcd=%h required 0 1 000000000",
                     out_valid, in_ready, out_bcd);
        end
    endtask

    task automatic test_corrupt();
        int n;
        start_op(32'd55555555);
        n = 0;
        in_valid = 1'b1;
        while (!out_valid && n < 40) begin
            in_bin = $urandom;
            tick();
            n++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (n !== 32 || out_bcd !== 36'h055555555 || out_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL corrupt: edges=%0d out_bcd=%h out_ovf=%b required 32 055555555 0", n, out_bcd, out_ovf);
        end
        release_result();
    endtask

    task automatic test_back_to_back();
        int n;
        start_op(32'd1);
        wait_valid(n);
        release_result();
        start_op(32'd4000000000);
        wait_valid(n);
        n_cmp++;
        if (n !== 32 || out_bcd !== 36'h000000000 || out_ovf !== 1'b1) begin
            n_bad++;
            $display("FAIL back_to_back: edges=%0d out_bcd=%h out_ovf=%b required 32 000000000 1", n, out_bcd, out_ovf);
        end
        release_result();
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        in_bin    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_zero();
        test_values();
        test_backpressure();
        test_reset_mid();
        test_reset_done();
        test_corrupt();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_serial.md
BIN_TO_BCD_SERIAL -- requirements
Module: bin_to_bcd_serial

Interface
REQ-001 The module SHALL have these ports, one per line: name  direction  width  meaning.
- clk  input  1  sole clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
- in_bin  input  32  unsigned binary operand; sampled only on the accept edge.
- in_valid  input  1  upstream asserts: in_bin is valid.
- in_ready  output  1  block can accept an operand.
- out_bcd  output  36  nine packed BCD digits; digit 0 in [3:0], digit 8 in [35:32].
- out_ovf  output  1  operand ≥ 1,000,000,000; out_bcd holds the low nine decimal digits.
- out_valid  output  1  out_bcd and out_ovf are valid.
- out_ready  input  1  downstream accepts the result.
REQ-002 The block SHALL have no parameters; all widths are fixed as listed.

Function
REQ-003 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-004 In IDLE: in_ready=1, out_valid=0; in all other states: in_ready=0.
REQ-005 Accept edge: rising edge with state IDLE and in_valid=1 -> latch in_bin into a 32-bit shift register, clear a 40-bit BCD scratch (ten digits), load the bit counter with 32, go to SHIFT.
REQ-006 Each SHIFT edge SHALL perform one double-dabble step: add 3 to every scratch digit ≥5, then shift {scratch, shift register} left one bit, MSB of the binary shifting in first, and decrement the counter.
REQ-007 After the 32nd SHIFT step the state SHALL be DONE; exactly 32 SHIFT edges follow the accept edge, and out_valid is first high in the cycle after the 32nd step (latency 33 edges, accept edge included).
REQ-008 In DONE: out_valid=1; out_bcd = scratch[35:0]; out_ovf = (scratch[39:36] != 0).
REQ-009 out_bcd and out_ovf SHALL stay stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-010 Edge with state DONE and out_ready=1 -> IDLE; no operand is accepted on that same edge (minimum issue interval 34 edges).
REQ-011 in_valid and in_bin changes while in SHIFT or DONE SHALL be ignored and SHALL NOT corrupt the conversion in progress.
REQ-012 out_ready while not in DONE SHALL have no effect.
REQ-013 In IDLE, out_bcd and out_ovf SHALL hold the last completed result (zero after reset).
REQ-014 Every scratch digit SHALL remain a legal BCD value (0-9) after every step; all arithmetic is unsigned, with no sign handling.

Reset
REQ-015 rst=1 on any edge SHALL force IDLE, clear the shift register, scratch and counter, and drive out_bcd=0, out_ovf=0, out_valid=0, in_ready=1 in the following cycle.
REQ-016 rst SHALL take priority over accept, shift and handshake events on the same edge, including a reset in the middle of SHIFT or during DONE; the partial result SHALL be discarded.
REQ-017 After rst deasserts, the first edge with in_valid=1 SHALL be a valid accept edge.

Verification
REQ-018 in_bin=0 -> after 33 edges out_valid=1, out_bcd=0x000000000, out_ovf=0.
REQ-019 in_bin=12345678 -> out_bcd=0x012345678, out_ovf=0; in_bin=999999999 -> out_bcd=0x999999999, out_ovf=0.
REQ-020 in_bin=1000000000 -> out_bcd=0x000000000, out_ovf=1; in_bin=0xFFFFFFFF -> out_bcd=0x294967295, out_ovf=1.
REQ-021 Backpressure: hold out_ready=0 for 10 cycles after out_valid rises -> out_bcd stable, in_ready=0 throughout, and a new in_valid is ignored; after one out_ready pulse -> IDLE next cycle.
REQ-022 Reset mid-conversion: assert rst on the 16th SHIFT edge -> next cycle IDLE, out_valid=0, out_bcd=0; a fresh operand 42 then yields 0x000000042.
REQ-023 Input corruption: change in_bin on every SHIFT cycle with in_valid=1 -> the result matches the value latched on the accept edge.
